regfile_scoreboard: RTL and testbench

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_scoreboard_pkg.sv | 16 +
 rtl/regfile_scoreboard_rdport.sv | 51 +++++
 rtl/regfile_scoreboard.sv | 104 ++++++++++
 tb/tb_regfile_scoreboard.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// Shared defaults and constants for the register-file scoreboard.
package regfile_scoreboard_pkg;

   localparam int unsigned XLEN_DEF = 32;
   localparam int unsigned NREG_DEF = 32;
   localparam int unsigned NRD_DEF  = 2;
   localparam int unsigned NWB_DEF  = 2;
   localparam int unsigned TAGW_DEF = 4;

   // Wide enough for any practical XLEN; users slice the low bits.
   localparam logic [127:0] ZERO_WORD = '0;

   localparam logic EN_ON  = 1'b1;
   localparam logic EN_OFF = 1'b0;

endpackage

// File: rtl/regfile_scoreboard_rdport.sv
// One combinational read port: stored value or writeback bypass, plus busy/tag.
module regfile_scoreboard_rdport
   import regfile_scoreboard_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEF,
   parameter int unsigned AW   = 5,
   parameter int unsigned NWB  = NWB_DEF,
   parameter int unsigned TAGW = TAGW_DEF
) (
   input  logic              en,
   input  logic [AW-1:0]     raddr,
   input  logic [XLEN-1:0]   st_data,
   input  logic              st_busy,
   input  logic [TAGW-1:0]   st_tag,
   input  logic [NWB-1:0]    wb_en,
   input  logic [NWB*AW-1:0] wb_rd,
   input  logic [NWB*TAGW-1:0] wb_tag,
   input  logic [NWB*XLEN-1:0] wb_data,
   output logic [XLEN-1:0]   rdata,
   output logic              rbusy,
   output logic [TAGW-1:0]   rtag
);

   logic            hit;
   logic            hit_clr;
   logic [XLEN-1:0] hit_data;

   // Pick the highest-index writeback targeting this address, then mux outputs.
   always_comb begin
      hit      = EN_OFF;
      hit_clr  = EN_OFF;
      hit_data = ZERO_WORD[XLEN-1:0];
      for (int k = 0; k < NWB; k++) begin
         if (wb_en[k] == EN_ON && wb_rd[k*AW +: AW] == raddr) begin
            hit      = EN_ON;
            hit_data = wb_data[k*XLEN +: XLEN];
            hit_clr  = st_busy && (st_tag == wb_tag[k*TAGW +: TAGW]);
         end
      end
      rdata = ZERO_WORD[XLEN-1:0];
      rbusy = 1'b0;
      rtag  = '0;
      // r0 is hardwired zero, so it never bypasses either.
      if (en == EN_ON && raddr != '0) begin
         rdata = hit ? hit_data : st_data;
         rbusy = hit_clr ? 1'b0 : st_busy;
         rtag  = st_tag;
      end
   end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with per-register busy/tag scoreboard and writeback bypass.
module regfile_scoreboard
   import regfile_scoreboard_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEF,
   parameter int unsigned NREG = NREG_DEF,
   parameter int unsigned NRD  = NRD_DEF,
   parameter int unsigned NWB  = NWB_DEF,
   parameter int unsigned TAGW = TAGW_DEF,
   localparam int unsigned AW  = $clog2(NREG)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 iss_en,
   input  logic [AW-1:0]        iss_rd,
   input  logic [TAGW-1:0]      iss_tag,
   input  logic [NWB-1:0]       wb_en,
   input  logic [NWB*AW-1:0]    wb_rd,
   input  logic [NWB*TAGW-1:0]  wb_tag,
   input  logic [NWB*XLEN-1:0]  wb_data,
   input  logic                 flush,
   input  logic [NRD-1:0]       re,
   input  logic [NRD*AW-1:0]    raddr,
   output logic [NRD*XLEN-1:0]  rdata,
   output logic [NRD-1:0]       rbusy,
   output logic [NRD*TAGW-1:0]  rtag
);

   logic [XLEN-1:0] regs_q [NREG];
   logic [XLEN-1:0] regs_d [NREG];
   logic [NREG-1:0] busy_q, busy_d;
   logic [TAGW-1:0] tag_q [NREG];
   logic [TAGW-1:0] tag_d [NREG];
   logic [NREG-1:0] clr;

   // Next state: writeback data and tag-matched busy clears, then issue, then flush.
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      tag_d  = tag_q;
      clr    = '0;
      for (int k = 0; k < NWB; k++) begin
         if (wb_en[k] == EN_ON && wb_rd[k*AW +: AW] != '0) begin
            regs_d[wb_rd[k*AW +: AW]] = wb_data[k*XLEN +: XLEN];
            if (busy_q[wb_rd[k*AW +: AW]] &&
                tag_q[wb_rd[k*AW +: AW]] == wb_tag[k*TAGW +: TAGW]) begin
               clr[wb_rd[k*AW +: AW]] = 1'b1;
            end
         end
      end
      busy_d = busy_d & ~clr;
      if (iss_en == EN_ON && iss_rd != '0 && flush != EN_ON) begin
         busy_d[iss_rd] = 1'b1;
         tag_d[iss_rd]  = iss_tag;
      end
      if (flush == EN_ON) begin
         busy_d = '0;
      end
      regs_d[0] = ZERO_WORD[XLEN-1:0];
      busy_d[0] = 1'b0;
      tag_d[0]  = '0;
   end

   // State registers, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
            tag_q[i]  <= '0;
         end
         busy_q <= '0;
      end else begin
         regs_q <= regs_d;
         tag_q  <= tag_d;
         busy_q <= busy_d;
      end
   end

   for (genvar j = 0; j < NRD; j++) begin : g_rd
      logic [AW-1:0] addr;
      assign addr = raddr[j*AW +: AW];

      regfile_scoreboard_rdport #(
         .XLEN (XLEN),
         .AW   (AW),
         .NWB  (NWB),
         .TAGW (TAGW)
      ) u_rdport (
         .en      (re[j] & ~rst),
         .raddr   (addr),
         .st_data (regs_q[addr]),
         .st_busy (busy_q[addr]),
         .st_tag  (tag_q[addr]),
         .wb_en   (wb_en),
         .wb_rd   (wb_rd),
         .wb_tag  (wb_tag),
         .wb_data (wb_data),
         .rdata   (rdata[j*XLEN +: XLEN]),
         .rbusy   (rbusy[j]),
         .rtag    (rtag[j*TAGW +: TAGW])
      );
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard (default parameters).
module tb_regfile_scoreboard;

   logic        clk = 1'b0;
   logic        rst;
   logic        iss_en;
   logic [4:0]  iss_rd;
   logic [3:0]  iss_tag;
   logic [1:0]  wb_en;
   logic [9:0]  wb_rd;
   logic [7:0]  wb_tag;
   logic [63:0] wb_data;
   logic        flush;
   logic [1:0]  re;
   logic [9:0]  raddr;
   logic [63:0] rdata;
   logic [1:0]  rbusy;
   logic [7:0]  rtag;

   int tests = 0;
   int fails = 0;

   regfile_scoreboard dut (
      .clk     (clk),
      .rst     (rst),
      .iss_en  (iss_en),
      .iss_rd  (iss_rd),
      .iss_tag (iss_tag),
      .wb_en   (wb_en),
      .wb_rd   (wb_rd),
      .wb_tag  (wb_tag),
      .wb_data (wb_data),
      .flush   (flush),
      .re      (re),
      .raddr   (raddr),
      .rdata   (rdata),
      .rbusy   (rbusy),
      .rtag    (rtag)
   );

   always #5 clk = ~clk;

   task automatic idle();
      iss_en = 0; iss_rd = 0; iss_tag = 0;
      wb_en = 0; wb_rd = 0; wb_tag = 0; wb_data = 0;
      flush = 0; re = 0; raddr = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      re = 2'b11; raddr = {5'd5, 5'd5};
      wb_en = 2'b01; wb_rd = {5'd0, 5'd5}; wb_data = {32'h0, 32'h1234_5678};
      iss_en = 1; iss_rd = 5'd5; iss_tag = 4'd9; flush = 0;
      #1;
      tests++; if (rdata !== 64'h0) begin fails++;
         $display("FAIL reset_rdata_in_rst got %h exp %h", rdata, 64'h0); end
      tests++; if (rbusy !== 2'b00) begin fails++;
         $display("FAIL reset_rbusy_in_rst got %b exp %b", rbusy, 2'b00); end
      tick(); tick();
      #3 rst = 1'b0;
      idle();
      re = 2'b11; raddr = {5'd5, 5'd5};
      #1;
      tests++; if (rdata !== 64'h0) begin fails++;
         $display("FAIL reset_r5_rdata got %h exp %h", rdata, 64'h0); end
      tests++; if (rbusy !== 2'b00) begin fails++;
         $display("FAIL reset_r5_rbusy got %b exp %b", rbusy, 2'b00); end
      tests++; if (rtag !== 8'h0) begin fails++;
         $display("FAIL reset_r5_rtag got %h exp %h", rtag, 8'h0); end
   endtask

   task automatic test_r0();
      idle();
      wb_en = 2'b01; wb_rd = {5'd0, 5'd0}; wb_data = {32'h0, 32'hDEAD_BEEF};
      iss_en = 1; iss_rd = 5'd0; iss_tag = 4'd3;
      re = 2'b01; raddr = {5'd0, 5'd0};
      #1;
      tests++; if (rdata[31:0] !== 32'h0) begin fails++;
         $display("FAIL r0_bypass got %h exp %h", rdata[31:0], 32'h0); end
      tick();
      idle();
      re = 2'b01; raddr = {5'd0, 5'd0};
      #1;
      tests++; if (rdata[31:0] !== 32'h0) begin fails++;
         $display("FAIL r0_stored got %h exp %h", rdata[31:0], 32'h0); end
      tests++; if (rbusy[0] !== 1'b0 || rtag[3:0] !== 4'h0) begin fails++;
         $display("FAIL r0_busy_tag got %b/%h exp 0/0", rbusy[0], rtag[3:0]); end
   endtask

   task automatic test_busy_clear();
      idle();
      iss_en = 1; iss_rd = 5'd3; iss_tag = 4'd2;
      re = 2'b01; raddr = {5'd0, 5'd3};
      #1;
      tests++; if (rbusy[0] !== 1'b0) begin fails++;
         $display("FAIL issue_not_bypassed got %b exp %b", rbusy[0], 1'b0); end
      tick();
      idle();
      re = 2'b01; raddr = {5'd0, 5'd3};
      #1;
      tests++; if (rbusy[0] !== 1'b1 || rtag[3:0] !== 4'd2) begin fails++;
         $display("FAIL r3_busy got %b/%h exp 1/2", rbusy[0], rtag[3:0]); end
      wb_en = 2'b01; wb_rd = {5'd0, 5'd3}; wb_tag = {4'd0, 4'd2};
      wb_data = {32'h0, 32'h11};
      #1;
      tests++; if (rdata[31:0] !== 32'h11 || rbusy[0] !== 1'b0) begin fails++;
         $display("FAIL r3_bypass got %h/%b exp 11/0", rdata[31:0], rbusy[0]); end
      tick();
      idle();
      re = 2'b01; raddr = {5'd0, 5'd3};
      #1;
      tests++; if (rdata[31:0] !== 32'h11 || rbusy[0] !== 1'b0) begin fails++;
         $display("FAIL r3_after got %h/%b exp 11/0", rdata[31:0], rbusy[0]); end
   endtask

   task automatic test_stale_tag();
      idle();
      iss_en = 1; iss_rd = 5'd4; iss_tag = 4'd1;
      tick();
      iss_tag = 4'd6;
      tick();
      idle();
      wb_en = 2'b01; wb_rd = {5'd0, 5'd4}; wb_tag = {4'd0, 4'd1};
      wb_data = {32'h0, 32'h22};
      re = 2'b01; raddr = {5'd0, 5'd4};
      #1;
      tests++; if (rdata[31:0] !== 32'h22 || rbusy[0] !== 1'b1) begin fails++;
         $display("FAIL stale_bypass got %h/%b exp 22/1", rdata[31:0], rbusy[0]); end
      tick();
      idle();
      re = 2'b01; raddr = {5'd0, 5'd4};
      #1;
      tests++; if (rdata[31:0] !== 32'h22) begin fails++;
         $display("FAIL stale_data got %h exp %h", rdata[31:0], 32'h22); end
      tests++; if (rbusy[0] !== 1'b1 || rtag[3:0] !== 4'd6) begin fails++;
         $display("FAIL stale_busy_tag got %b/%h exp 1/6", rbusy[0], rtag[3:0]); end
   endtask

   task automatic test_dual_wb();
      idle();
      wb_en = 2'b11; wb_rd = {5'd7, 5'd7}; wb_data = {32'hBB, 32'hAA};
      re = 2'b11; raddr = {5'd7, 5'd7};
      #1;
      tests++; if (rdata !== {32'hBB, 32'hBB}) begin fails++;
         $display("FAIL dual_bypass got %h exp %h", rdata, {32'hBB, 32'hBB}); end
      tick();
      idle();
      re = 2'b11; raddr = {5'd7, 5'd7};
      #1;
      tests++; if (rdata !== {32'hBB, 32'hBB}) begin fails++;
         $display("FAIL dual_stored got %h exp %h", rdata, {32'hBB, 32'hBB}); end
   endtask

   task automatic test_flush();
      idle();
      iss_en = 1; iss_rd = 5'd9; iss_tag = 4'd3; flush = 1;
      tick();
      idle();
      re = 2'b01; raddr = {5'd0, 5'd9};
      #1;
      tests++; if (rbusy[0] !== 1'b0) begin fails++;
         $display("FAIL flush_vs_issue got %b exp %b", rbusy[0], 1'b0); end
      wb_en = 2'b11; wb_rd = {5'd11, 5'd10}; wb_data = {32'h1111, 32'h1010};
      tick();
      idle();
      iss_en = 1; iss_rd = 5'd10; iss_tag = 4'd4;
      tick();
      iss_rd = 5'd11; iss_tag = 4'd5;
      tick();
      idle();
      re = 2'b11; raddr = {5'd11, 5'd10};
      #1;
      tests++; if (rbusy !== 2'b11) begin fails++;
         $display("FAIL flush_pre_busy got %b exp %b", rbusy, 2'b11); end
      flush = 1;
      tick();
      idle();
      re = 2'b11; raddr = {5'd11, 5'd10};
      #1;
      tests++; if (rbusy !== 2'b00) begin fails++;
         $display("FAIL flush_busy got %b exp %b", rbusy, 2'b00); end
      tests++; if (rdata !== {32'h1111, 32'h1010}) begin fails++;
         $display("FAIL flush_data got %h exp %h", rdata, {32'h1111, 32'h1010}); end
      tests++; if (rtag !== {4'd5, 4'd4}) begin fails++;
         $display("FAIL flush_tags got %h exp %h", rtag, {4'd5, 4'd4}); end
   endtask

   task automatic test_async_reset();
      idle();
      iss_en = 1; iss_rd = 5'd12; iss_tag = 4'd7;
      wb_en = 2'b01; wb_rd = {5'd0, 5'd12}; wb_data = {32'h0, 32'h55};
      tick();
      idle();
      re = 2'b01; raddr = {5'd0, 5'd12};
      #1;
      tests++; if (rdata[31:0] !== 32'h55 || rbusy[0] !== 1'b1 || rtag[3:0] !== 4'd7)
      begin fails++;
         $display("FAIL r12_pre got %h/%b/%h exp 55/1/7", rdata[31:0], rbusy[0], rtag[3:0]);
      end
      #1 rst = 1'b1;
      #1;
      tests++; if (rdata !== 64'h0 || rbusy !== 2'b00 || rtag !== 8'h0) begin fails++;
         $display("FAIL async_rst_out got %h/%b/%h exp 0/0/0", rdata, rbusy, rtag); end
      #2 rst = 1'b0;
      #1;
      tests++; if (rdata[31:0] !== 32'h0 || rbusy[0] !== 1'b0) begin fails++;
         $display("FAIL r12_post got %h/%b exp 0/0", rdata[31:0], rbusy[0]); end
   endtask

   initial begin
      test_reset();
      tick();
      test_r0();
      tick();
      test_busy_clear();
      tick();
      test_stale_tag();
      tick();
      test_dual_wb();
      tick();
      test_flush();
      tick();
      test_async_reset();
      tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
